// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the shared multiplier controller.
// Provides the FSM state enum, operand/product widths and the round-robin picker.
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int OPW    = 16;
  localparam int PRODW  = 32;
  localparam int MAXREQ = 8;
  localparam int IXW    = 3;

  // First valid index at or after ptr, wrapping modulo n.
  function automatic logic [IXW-1:0] rr_pick(
    input logic [MAXREQ-1:0] valid,
    input logic [IXW-1:0]    ptr,
    input int                n
  );
    logic [IXW-1:0] pick;
    logic           hit;
    int             idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!hit && k < n && valid[idx[IXW-1:0]]) begin
        pick = IXW'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_share_ctrl_arb.sv
// Combinational round-robin arbiter for the shared multiplier.
// Ports: valid/ptr in; one-hot grant, granted index and any-valid out.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [IXW-1:0] pick;

  always_comb begin
    pick  = rr_pick(MAXREQ'(valid), IXW'(ptr), NREQ);
    idx   = ID_W'(pick);
    any   = |valid;
    grant = '0;
    for (int i = 0; i < NREQ; i++)
      grant[i] = any && (int'(pick) == i);
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one iterative 16x16 multiplier among NREQ requesters (round-robin).
// Ports: req_* valid/ready in, resp_* tagged product out, mul_* engine side, busy.
// Option: MUL_SHARE_ZERO_BYPASS_EN answers zero-operand ops without the engine.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int TMO_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_x,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [ID_W-1:0]  resp_id,
  output logic [PRODW-1:0] resp_data,
  output logic             resp_err,
  output logic             mul_start,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_x,
  input  logic             mul_done,
  input  logic [31:0]      mul_result,
  output logic             busy
);

  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TMO_CYC - 1);

  state_t          state, nxt;
  logic [ID_W-1:0] rr_ptr, gidx, nxt_ptr;
  logic [NREQ-1:0] grant;
  logic            any;
  logic [31:0]     a_sel, x_sel;
  logic [TW-1:0]   timer;
  logic            tmo;
  logic            skip;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  always_comb begin
    a_sel = '0;
    x_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*32 +: 32];
        x_sel = req_x[i*32 +: 32];
      end
    end
  end

`ifdef MUL_SHARE_ZERO_BYPASS_EN
  assign skip = (a_sel[OPW-1:0] == '0) || (x_sel[OPW-1:0] == '0);
`else
  assign skip = 1'b0;
`endif

  assign tmo     = (timer == TLAST);
  assign nxt_ptr = (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (any) nxt = skip ? RESP : ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (mul_done || tmo) nxt = RESP;
      RESP:    if (resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    mul_start  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:    req_ready  = grant;
      ISSUE:   mul_start  = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      mul_a     <= '0;
      mul_x     <= '0;
      resp_id   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      timer     <= '0;
    end else begin
      unique case (state)
        IDLE: if (any) begin
          mul_a   <= a_sel;
          mul_x   <= x_sel;
          resp_id <= gidx;
          rr_ptr  <= nxt_ptr;
          if (skip) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
          end
        end
        ISSUE: timer <= '0;
        // A done arriving on the expiry cycle still wins.
        WAIT: begin
          if (mul_done) begin
            resp_data <= mul_result;
            resp_err  <= 1'b0;
          end else if (tmo) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl with a behavioural multiplier engine.
// Table-driven ops plus hand sequences for arbitration, timeout, stall and reset.
module tb_mul_share_ctrl;

  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [63:0]     req_a, req_x;
  logic            resp_valid, resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic            mul_start;
  logic [31:0]     mul_a, mul_x;
  logic            mul_done;
  logic [31:0]     mul_result;
  logic            busy;

  mul_share_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_x      (req_x),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_x      (mul_x),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            err;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] x;
    logic [31:0] prod;
  } vec_t;

  rsp_t sb[$];
  vec_t vt[6];

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int eng_lat = 8;
  bit eng_hang = 1'b0;
  int eng_cnt;
  logic [31:0] eng_prod;

  function automatic rsp_t mk(int id, logic [31:0] d, logic e);
    rsp_t r;
    r.id   = ID_W'(id);
    r.data = d;
    r.err  = e;
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Engine model: product of the signed low halves, done after eng_lat cycles.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_cnt    = 0;
      mul_done   = 1'b0;
      mul_result = '0;
    end else begin
      mul_done = 1'b0;
      if (mul_start) begin
        eng_prod = 32'(int'($signed(mul_a[15:0])) * int'($signed(mul_x[15:0])));
        eng_cnt  = eng_hang ? 0 : eng_lat;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          mul_done   = 1'b1;
          mul_result = eng_prod;
        end
      end
    end
  end

  // Response scoreboard and start-pulse counter.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mul_start) starts++;
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got id=%0d data=%0h err=%0b want none",
                   resp_id, resp_data, resp_err);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("resp", {resp_id, resp_err, resp_data}, {e.id, e.err, e.data});
        end
      end
    end
  end

  task automatic set_req(int r, logic [31:0] a, logic [31:0] x);
    @(posedge clk);
    #1;
    req_a[r*32 +: 32] = a;
    req_x[r*32 +: 32] = x;
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_grant(int r, rsp_t e, bit push);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    chk("grant", 128'(got), 128'd1);
    if (got && push) sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
    chk("drain", 128'(ok), 128'd1);
  endtask

  task automatic chk_reset_outs(string name);
    chk(name, {req_ready, resp_valid, resp_id, resp_err, mul_start, busy,
               resp_data, mul_a, mul_x}, 128'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int n;
    bit got;

    vt[0] = '{32'h0000_0003, 32'h0000_0007, 32'h0000_0015};
    vt[1] = '{32'h0000_FFFF, 32'h0000_0005, 32'hFFFF_FFFB};
    vt[2] = '{32'h0000_7FFF, 32'h0000_7FFF, 32'h3FFF_0001};
    vt[3] = '{32'h0000_8000, 32'h0000_8000, 32'h4000_0000};
    vt[4] = '{32'h0000_8000, 32'h0000_7FFF, 32'hC000_8000};
    vt[5] = '{32'hABCD_0100, 32'h0000_0002, 32'h0000_0200};

    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_x      = '0;
    resp_ready = 1'b1;
    #12;
    chk_reset_outs("reset_state");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single-requester ops from the table, one start pulse each.
    foreach (vt[i]) begin
      s0 = starts;
      set_req(0, vt[i].a, vt[i].x);
      wait_grant(0, mk(0, vt[i].prod, 1'b0), 1'b1);
      drain();
      chk("starts_per_op", 128'(starts - s0), 128'd1);
    end

    // Both requesters always valid: grants alternate from rr_ptr=0.
    do_reset();
    @(posedge clk);
    #1;
    req_a = {32'h0000_FFFE, 32'h0000_0002};
    req_x = {32'h0000_0009, 32'h0000_0003};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (|req_ready) got = 1'b1;
      end
      chk("rr_grant", 128'(req_ready), 128'(2'b01 << (k % 2)));
      sb.push_back(mk(k % 2, (k % 2) ? 32'hFFFF_FFEE : 32'h0000_0006, 1'b0));
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Engine never completes: 64 WAIT cycles between start pulse and response.
    eng_hang = 1'b1;
    set_req(1, 32'h11, 32'h22);
    wait_grant(1, mk(1, 32'h0, 1'b1), 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mul_start) got = 1'b1;
    end
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid) break;
      n++;
    end
    chk("tmo_cycles", 128'(n), 128'd64);
    drain();
    eng_hang = 1'b0;

    // Consumer stalls: response held, pending request not granted.
    resp_ready = 1'b0;
    set_req(1, 32'h5, 32'h6);
    wait_grant(1, mk(1, 32'd30, 1'b0), 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    set_req(0, 32'h1, 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("resp_hold", {resp_valid, resp_id, resp_data, req_ready},
          {1'b1, 1'b1, 32'd30, 2'b00});
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    wait_grant(0, mk(0, 32'd1, 1'b0), 1'b1);
    drain();

    // Reset in WAIT drops the op; arbitration restarts at requester 0.
    eng_lat = 20;
    set_req(0, 32'h3, 32'h3);
    wait_grant(0, mk(0, 32'd9, 1'b0), 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("reset_in_wait");
    #20;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    eng_lat = 8;
    @(posedge clk);
    #1;
    req_a = {32'h0000_0006, 32'h0000_0004};
    req_x = {32'h0000_0007, 32'h0000_0005};
    req_valid = 2'b11;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (|req_ready) got = 1'b1;
    end
    chk("post_reset_grant", 128'(req_ready), 128'(2'b01));
    sb.push_back(mk(0, 32'd20, 1'b0));
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    // Zero operand.
    s0 = starts;
    set_req(0, 32'h0, 32'h1234);
    wait_grant(0, mk(0, 32'h0, 1'b0), 1'b1);
    drain();
`ifdef MUL_SHARE_ZERO_BYPASS_EN
    chk("zero_starts", 128'(starts - s0), 128'd0);
`else
    chk("zero_starts", 128'(starts - s0), 128'd1);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
